// File: rtl/pipe_adder_pkg.sv
// Shared constants, per-stage tag struct and configuration legality check for pipe_cla_adder.
// Saturation support is enabled by defining PIPE_ADDER_SAT_EN.
package pipe_adder_pkg;

    localparam int GROUP_W = 4;

    // Control bits that travel with a beat alongside its operand and sum bits.
    typedef struct packed {
        logic carry;
        logic sub;
        logic sat;
    } stage_tag_t;

    // Every stage must hold a whole number of lookahead groups.
    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (width >= GROUP_W) &&
               (width % GROUP_W == 0) && (width % (GROUP_W * stages) == 0);
    endfunction

endpackage

// File: rtl/cla4_group.sv
// Combinational 4-bit carry-lookahead group: per-bit sum, carry out and group generate/propagate.
module cla4_group
    import pipe_adder_pkg::*;
(
    input  logic               cin,
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    output logic [GROUP_W-1:0] sum,
    output logic               cout,
    output logic               g,
    output logic               p
);

    logic [GROUP_W-1:0] w_gen;
    logic [GROUP_W-1:0] w_prp;
    logic [GROUP_W-1:0] w_c;

    assign w_gen = a & b;
    assign w_prp = a ^ b;

    assign w_c[0] = cin;
    assign w_c[1] = w_gen[0] | (w_prp[0] & cin);
    assign w_c[2] = w_gen[1] | (w_prp[1] & w_gen[0]) | (w_prp[1] & w_prp[0] & cin);
    assign w_c[3] = w_gen[2] | (w_prp[2] & w_gen[1]) | (w_prp[2] & w_prp[1] & w_gen[0]) |
                    (w_prp[2] & w_prp[1] & w_prp[0] & cin);

    assign g = w_gen[3] | (w_prp[3] & w_gen[2]) | (w_prp[3] & w_prp[2] & w_gen[1]) |
               (w_prp[3] & w_prp[2] & w_prp[1] & w_gen[0]);
    assign p = &w_prp;

    assign cout = g | (p & cin);
    assign sum  = w_prp ^ w_c;

endmodule

// File: rtl/pipe_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor, WIDTH/STAGES bits resolved per register slice,
// valid/ready on both sides. Define PIPE_ADDER_SAT_EN to add the in_sat signed-saturation option.
module pipe_cla_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
`ifdef PIPE_ADDER_SAT_EN
    input  logic             in_sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int S    = WIDTH / STAGES;
    localparam int NG   = S / GROUP_W;
    localparam int LAST = STAGES - 1;

    // Handshake: a beat moves from stage k-1 into stage k on the edge where
    // w_v[k-1] && w_ready[k]; w_ready[k] = !v[k] || w_ready[k+1], w_ready[STAGES] = out_ready.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
        stage_tag_t       tag;
    } payload_t;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("pipe_cla_adder: WIDTH must be a multiple of 4*STAGES");
    end

    payload_t      w_pl [STAGES];
    logic          w_v  [STAGES];
    logic [STAGES:0] w_ready;
    logic          w_sat_req;

`ifdef PIPE_ADDER_SAT_EN
    assign w_sat_req = in_sat;
`else
    assign w_sat_req = 1'b0;
`endif

    assign w_ready[STAGES] = out_ready;
    assign in_ready        = w_ready[0];
    assign out_valid       = w_v[LAST];
    assign out_sum         = w_pl[LAST].sum;
    assign out_cout        = w_pl[LAST].tag.carry;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        payload_t         w_src;
        logic             w_src_v;
        payload_t         w_nxt;
        payload_t         r_pl;
        logic             r_v;
        logic [S-1:0]     w_slice;
        logic [NG-1:0]    w_gc;
        logic [NG-1:0]    w_gg;
        logic [NG-1:0]    w_gp;
        logic [NG-1:0]    w_gco;
        logic [WIDTH-1:0] w_stage_sum;
        logic             w_co;

        // Operand B is inverted once at entry; later stages only see effective B.
        if (k == 0) begin : g_head
            always_comb begin
                w_src           = '0;
                w_src.a         = in_a;
                w_src.b         = in_sub ? ~in_b : in_b;
                w_src.tag.carry = in_cin ^ in_sub;
                w_src.tag.sub   = in_sub;
                w_src.tag.sat   = w_sat_req;
            end
            assign w_src_v = in_valid;
        end else begin : g_body
            assign w_src   = w_pl[k-1];
            assign w_src_v = w_v[k-1];
        end

        assign w_gc[0] = w_src.tag.carry;

        for (genvar g = 0; g < NG; g++) begin : g_grp
            cla4_group u_grp (
                .cin  (w_gc[g]),
                .a    (w_src.a[k*S + g*GROUP_W +: GROUP_W]),
                .b    (w_src.b[k*S + g*GROUP_W +: GROUP_W]),
                .sum  (w_slice[g*GROUP_W +: GROUP_W]),
                .cout (w_gco[g]),
                .g    (w_gg[g]),
                .p    (w_gp[g])
            );
            if (g < NG - 1) begin : g_ripple
                assign w_gc[g+1] = w_gg[g] | (w_gp[g] & w_gc[g]);
            end
        end

        assign w_co = w_gco[NG-1];

        always_comb begin
            w_stage_sum              = w_src.sum;
            w_stage_sum[k*S +: S]    = w_slice;
        end

        if (k == LAST) begin : g_last
            logic             w_c_msb;
            logic             w_ovf;
            logic [WIDTH-1:0] w_res;
            logic             r_ovf;
            logic             r_zero;

            assign w_c_msb = w_src.a[WIDTH-1] ^ w_src.b[WIDTH-1] ^ w_stage_sum[WIDTH-1];
            assign w_ovf   = w_c_msb ^ w_co;

`ifdef PIPE_ADDER_SAT_EN
            // On overflow the wrapped sign bit is the opposite of the true result's sign.
            always_comb begin
                w_res = w_stage_sum;
                if (w_src.tag.sat && w_ovf) begin
                    w_res = w_stage_sum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                                 : {1'b1, {(WIDTH-1){1'b0}}};
                end
            end
`else
            assign w_res = w_stage_sum;
`endif

            always_comb begin
                w_nxt           = w_src;
                w_nxt.sum       = w_res;
                w_nxt.tag.carry = w_co;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ovf  <= 1'b0;
                    r_zero <= 1'b0;
                end else if (w_ready[k] && w_src_v) begin
                    r_ovf  <= w_ovf;
                    r_zero <= (w_res == '0);
                end
            end

            assign out_ovf  = r_ovf;
            assign out_zero = r_zero;
        end else begin : g_mid
            always_comb begin
                w_nxt           = w_src;
                w_nxt.sum       = w_stage_sum;
                w_nxt.tag.carry = w_co;
            end
        end

        // Payload only updates on a real transfer so a drained stage keeps its last value.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_v  <= 1'b0;
                r_pl <= '0;
            end else if (w_ready[k]) begin
                r_v <= w_src_v;
                if (w_src_v) begin
                    r_pl <= w_nxt;
                end
            end
        end

        assign w_ready[k] = !r_v || w_ready[k+1];
        assign w_pl[k]    = r_pl;
        assign w_v[k]     = r_v;
    end

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Self-checking bench for pipe_cla_adder: vector table, random stream against an arithmetic
// model, backpressure, mid-stream reset and an 8-stage instance.
module tb_pipe_cla_adder;

    localparam int W   = 32;
    localparam int ST  = 2;
    localparam int ST8 = 8;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    localparam int RW = $bits(res_t);

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         cin;
        logic         sat;
        res_t         exp;
    } vec_t;

`ifdef PIPE_ADDER_SAT_EN
    localparam bit SAT_ON = 1'b1;
`else
    localparam bit SAT_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, in_sub, in_cin, in_sat;
    logic [W-1:0] in_a, in_b;
    logic         out_valid, out_ready, out_cout, out_ovf, out_zero;
    logic [W-1:0] out_sum;

    logic         in_valid8, in_ready8, in_sub8, in_cin8, in_sat8;
    logic [W-1:0] in_a8, in_b8;
    logic         out_valid8, out_ready8, out_cout8, out_ovf8, out_zero8;
    logic [W-1:0] out_sum8;

    pipe_cla_adder #(.WIDTH(W), .STAGES(ST)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_cin    (in_cin),
`ifdef PIPE_ADDER_SAT_EN
        .in_sat    (in_sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    pipe_cla_adder #(.WIDTH(W), .STAGES(ST8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .in_a      (in_a8),
        .in_b      (in_b8),
        .in_sub    (in_sub8),
        .in_cin    (in_cin8),
`ifdef PIPE_ADDER_SAT_EN
        .in_sat    (in_sat8),
`endif
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_sum   (out_sum8),
        .out_cout  (out_cout8),
        .out_ovf   (out_ovf8),
        .out_zero  (out_zero8)
    );

    // ---------------- scoreboard state ----------------
    int            n_checks = 0;
    int            n_errors = 0;
    logic [RW-1:0] exp_q[$];
    int            cyc = 0;
    int            acc_cnt = 0;
    int            emit_cnt = 0;
    int            first_emit = 0;
    int            last_emit = 0;
    bit            acc = 1'b0;
    bit            held_valid = 1'b0;
    res_t          held;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: true signed result in 64-bit arithmetic, raw carry from 33-bit unsigned sum.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input logic cin, input logic sat);
        res_t        r;
        logic [W:0]  raw;
        longint      ta;
        raw = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{W{1'b0}}, cin ^ sub};
        if (sub) ta = longint'($signed(a)) - longint'($signed(b)) - longint'(cin);
        else     ta = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        r.ovf  = (ta > 64'sh7FFF_FFFF) || (ta < -64'sh8000_0000);
        r.sum  = raw[W-1:0];
        if (sat && r.ovf) r.sum = (ta > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        r.cout = raw[W];
        r.zero = (r.sum == '0);
        return r;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // One cycle of the streaming harness; entered and left at posedge+1.
    task automatic tick();
        res_t got;
        @(negedge clk);
        got = {out_sum, out_cout, out_ovf, out_zero};
        if (held_valid) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", got, held);
        end
        held_valid = out_valid && !out_ready;
        held       = got;
        if (out_valid && out_ready) begin
            emit_cnt++;
            if (emit_cnt == 1) first_emit = cyc;
            last_emit = cyc;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_result: got %0h expected none", got);
            end else begin
                check("result", got, exp_q.pop_front());
            end
        end
        acc = in_valid && in_ready;
        if (acc) begin
            acc_cnt++;
            exp_q.push_back(model(in_a, in_b, in_sub, in_cin, in_sat & SAT_ON));
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply_vec(input vec_t v, input int idx);
        int   n;
        res_t got;
        in_a = v.a; in_b = v.b; in_sub = v.sub; in_cin = v.cin; in_sat = v.sat;
        in_valid = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        check($sformatf("vec%0d_in_ready", idx), in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        got = {out_sum, out_cout, out_ovf, out_zero};
        check($sformatf("vec%0d_latency", idx), n, ST - 1);
        check($sformatf("vec%0d_sum", idx), got.sum, v.exp.sum);
        check($sformatf("vec%0d_cout", idx), got.cout, v.exp.cout);
        check($sformatf("vec%0d_ovf", idx), got.ovf, v.exp.ovf);
        check($sformatf("vec%0d_zero", idx), got.zero, v.exp.zero);
    endtask

    task automatic set_bp(input int i);
        in_valid = 1'b1;
        in_a = 32'h1111_1111 * (i + 1);
        in_b = 32'h0F0F_0F0F + i;
        in_sub = i[0];
        in_cin = i[1];
        in_sat = 1'b0;
    endtask

    task automatic run8(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic cin, input logic sat, input string tag, output res_t got);
        int   n;
        res_t e;
        e = model(a, b, sub, cin, sat & SAT_ON);
        in_a8 = a; in_b8 = b; in_sub8 = sub; in_cin8 = cin; in_sat8 = sat;
        in_valid8 = 1'b1;
        out_ready8 = 1'b1;
        n = 0;
        while (!in_ready8 && n < 20) begin @(posedge clk); #1; n++; end
        check({tag, "_in_ready"}, in_ready8, 1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 30) begin @(posedge clk); #1; n++; end
        check({tag, "_latency"}, n, ST8 - 1);
        got = {out_sum8, out_cout8, out_ovf8, out_zero8};
        check({tag, "_model"}, got, e);
        @(posedge clk); #1;
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs[12];
    int   n_vec;

    initial begin
        int   bp_i;
        int   n;
        res_t r8;

        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0; in_sat = 1'b0;
        out_ready = 1'b1;
        in_valid8 = 1'b0; in_a8 = '0; in_b8 = '0; in_sub8 = 1'b0; in_cin8 = 1'b0; in_sat8 = 1'b0;
        out_ready8 = 1'b1;

        n_vec = 0;
        vecs[n_vec++] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, '{32'h0001_0000, 1'b0, 1'b0, 1'b0}};
        vecs[n_vec++] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};
        vecs[n_vec++] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0}};
        vecs[n_vec++] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};
        vecs[n_vec++] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}};
        vecs[n_vec++] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 1'b0, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}};
        vecs[n_vec++] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 1'b0, '{32'h0000_0006, 1'b1, 1'b0, 1'b0}};
        vecs[n_vec++] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b1, 1'b1}};
        vecs[n_vec++] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0}};
`ifdef PIPE_ADDER_SAT_EN
        vecs[n_vec++] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, '{32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0}};
        vecs[n_vec++] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, '{32'h8000_0000, 1'b1, 1'b1, 1'b0}};
`endif

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_cout", out_cout, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_out_zero", out_zero, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst8_out_valid", out_valid8, 0);

        // Vector table
        for (int i = 0; i < n_vec; i++) apply_vec(vecs[i], i);
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Random stream with random backpressure
        acc = 1'b0;
        in_valid = 1'b0;
        held_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_a   = pick();
                in_b   = pick();
                in_sub = $urandom_range(0, 1);
                in_cin = $urandom_range(0, 1);
                in_sat = $urandom_range(0, 1);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin tick(); n++; end
        check("rand_drain", exp_q.size(), 0);

        // Backpressure: full pipe holds exactly STAGES beats
        out_ready = 1'b0;
        acc_cnt = 0;
        bp_i = 0;
        set_bp(0);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (acc) begin
                bp_i++;
                if (bp_i < 5) set_bp(bp_i);
                else in_valid = 1'b0;
            end
        end
        check("bp_accepts", acc_cnt, ST);
        check("bp_in_ready_low", in_ready, 0);
        out_ready = 1'b1;
        emit_cnt = 0;
        n = 0;
        while (emit_cnt < 5 && n < 30) begin
            tick();
            n++;
            if (acc) begin
                bp_i++;
                if (bp_i < 5) set_bp(bp_i);
                else in_valid = 1'b0;
            end
        end
        tick();
        check("bp_emits", emit_cnt, 5);
        check("bp_span", last_emit - first_emit, 4);
        check("bp_total_accepts", acc_cnt, 5);
        check("bp_queue_empty", exp_q.size(), 0);

        // Reset with two beats in flight and a beat presented on the reset cycle
        out_ready = 1'b0;
        acc_cnt = 0;
        set_bp(7);
        n = 0;
        while (acc_cnt < 2 && n < 10) begin
            tick();
            n++;
            if (acc) set_bp(8 + acc_cnt);
        end
        check("rstm_inflight", acc_cnt, 2);
        set_bp(12);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        held_valid = 1'b0;
        check("rstm_out_valid", out_valid, 0);
        check("rstm_in_ready", in_ready, 1);
        out_ready = 1'b1;
        emit_cnt = 0;
        repeat (6) tick();
        check("rstm_no_emit", emit_cnt, 0);

        // 8-stage instance
        run8(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0, "s8_fixed", r8);
        check("s8_sum", r8.sum, 0);
        check("s8_cout", r8.cout, 1);
        check("s8_zero", r8.zero, 1);
        for (int i = 0; i < 4; i++) begin
            run8(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $sformatf("s8_rand%0d", i), r8);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        n_checks++;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_cla_adder.md
# pipe_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor. It is the successor to the fixed 4-bit lookahead adder. The datapath is built from 4-bit lookahead groups, and the operand width is split across `STAGES` register slices so wide adds close timing at core clock. A valid/ready handshake on both sides supports backpressure and bubble collapse. It sits between operand-issue logic and the writeback/flag path of the ALU.

## Interface
- `WIDTH`, 32: operand width in bits. Must be a multiple of 4 and of `4*STAGES`.
- `STAGES`, 2: pipeline depth, 1..`WIDTH/4`. Each stage resolves `WIDTH/STAGES` bits.
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: operand beat valid.
- `in_ready`  out  1: block accepts the beat this cycle.
- `in_a`  in  `WIDTH`: operand A.
- `in_b`  in  `WIDTH`: operand B.
- `in_sub`  in  1: 1 = A − B, 0 = A + B.
- `in_cin`  in  1: carry-in for add, borrow-in for subtract.
- `in_sat`  in  1: signed saturation request. Present only when `PIPE_ADDER_SAT_EN` is defined.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer accepts the result.
- `out_sum`  out  `WIDTH`: result.
- `out_cout`  out  1: raw carry out of the MSB group.
- `out_ovf`  out  1: signed overflow.
- `out_zero`  out  1: `out_sum` == 0.

## Operation
- Effective B = `in_sub ? ~in_b : in_b`. Carry into bit 0 = `in_cin ^ in_sub`, so subtract computes A + ~B + !borrow.
- Stage k (0 = LSB) computes slice bits [(k+1)·S−1 : k·S], where S = `WIDTH/STAGES`.
  - The slice is built from S/4 lookahead groups with a ripple of group carries inside the stage.
  - Stage k registers its slice sum, its carry-out, the not-yet-processed upper operand bits, the `in_sub`/`in_sat` tags, and the already-computed lower sum bits.
- `out_cout` = carry out of bit `WIDTH−1`. For subtract, `out_cout` = 1 means no borrow.
- `out_ovf` = carry into bit `WIDTH−1` XOR carry out of bit `WIDTH−1`.
- `out_zero` is computed on the final (possibly saturated) `out_sum`.
- Each stage has a valid bit v[k]. Stage k loads when `!v[k] || ready[k+1]`, where ready[STAGES] = `out_ready`. Empty slots are therefore filled while downstream stalls (bubble collapse).
- `in_ready` = `!v[0] || ready[1]`. A beat transfers on `in_valid && in_ready`.
- Upstream holds `in_*` stable while `in_valid && !in_ready`. `out_*` are held stable while `out_valid && !out_ready`.
- Results leave in issue order. No beat is dropped or duplicated.

## Timing
- Latency: a beat accepted at edge N appears on `out_*` after edge N+`STAGES−1`, i.e. valid in the cycle following that edge with no stalls. `STAGES`=1 gives one registered cycle.
- Throughput: one beat per cycle while `out_ready` = 1.
- Reset: all v[k] = 0. `out_valid` = 0, `out_sum` = 0, `out_cout` = 0, `out_ovf` = 0, `out_zero` = 0. `in_ready` = 1 in the first cycle after reset.
- Reset mid-operation discards every in-flight beat. The beat presented on the reset cycle is not accepted.
- Full pipeline with `out_ready` = 0: `in_ready` = 0 in the same cycle (combinational path from `out_ready` through the stage chain).
- Simultaneous accept and emit at full occupancy is lossless.

## Configuration
- `PIPE_ADDER_SAT_EN` defined:
  - `in_sat` port exists.
  - When the tagged beat has `in_sat` = 1 and overflow occurs, `out_sum` clamps to 0x7FF…F if the true result is positive, or 0x800…0 if negative.
  - `out_ovf` still reports the raw overflow.
  - `out_cout` is unaffected.
- Not defined:
  - No `in_sat` port.
  - `out_sum` always wraps modulo 2^`WIDTH`.
  - No saturation logic is compiled in.

## Structure
- Package `pipe_adder_pkg`:
  - `GROUP_W` = 4.
  - Per-stage payload typedef: sum bits, carry, sub/sat tags.
  - Elaboration checks on legal `WIDTH`/`STAGES`.
- Sub-module `cla4_group`:
  - Combinational 4-bit generate/propagate lookahead.
  - Ports: cin, a[3:0], b[3:0]; outputs sum[3:0], cout, group G/P.
  - Instantiated `WIDTH/4` times.
- Top-level contains only the stage registers, the handshake chain, flags and optional saturation.

## Test plan
All scenarios use `WIDTH`=32, `STAGES`=2 unless noted.
- Add with carry ripple: A=0x0000FFFF, B=0x00000001, cin=0, add. Result after 2 cycles: sum=0x00010000, cout=0, ovf=0, zero=0. The carry crosses the stage boundary at bit 16.
- Subtract to zero: A=B=0x12345678, sub, cin=0. Result: sum=0, cout=1, zero=1, ovf=0.
- Signed overflow: A=0x7FFFFFFF, B=1, add. Result: sum=0x80000000, ovf=1, cout=0. With `PIPE_ADDER_SAT_EN` and `in_sat`=1: sum=0x7FFFFFFF, ovf=1.
- Backpressure: stream 5 beats with `out_ready` held 0. `in_ready` drops after exactly 2 accepts. Release `out_ready`; all 5 results emerge in order, one per cycle, with no duplicates.
- Reset mid-stream: 2 beats in flight, assert `rst` one cycle. Next cycle: `out_valid`=0, `in_ready`=1. The flushed results never appear.
- `STAGES`=8, `WIDTH`=32: A=0xFFFFFFFF, B=0, cin=1. Result after 8 cycles: sum=0, cout=1, zero=1.
